spi_cfg_sequencer: RTL and testbench
====================================

Name: spi_cfg_sequencer

Overview:
SPI controller that configures the on-chip SPI register-map peripheral, which holds the output-enable, PWM-enable and PWM-duty registers. Two independent requesters (e.g. host bridge and a power-on init ROM) issue register writes. The block arbitrates between them round-robin and serializes each write into one 16-bit SPI mode-0 frame on sclk/copi/ncs. All SPI outputs are registered and paced slowly enough for the peripheral's 2-flop synchronizers and SCLK edge detector.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal 4..255 (8-bit counter)
CS_GAP, 8, minimum clk cycles ncs stays high between frames; legal 2..255

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req0_valid  in  1  requester 0 has a write pending
req0_ready  out  1  requester 0 write accepted this cycle
req0_addr  in  7  requester 0 register address
req0_data  in  8  requester 0 write data
req1_valid  in  1  requester 1 has a write pending
req1_ready  out  1  requester 1 write accepted this cycle
req1_addr  in  7  requester 1 register address
req1_data  in  8  requester 1 write data
sclk  out  1  SPI serial clock, idle low
copi  out  1  SPI data to peripheral
ncs  out  1  SPI chip select, active low
busy  out  1  high from accept through end of GAP
done  out  1  one-cycle pulse at frame completion
done_id  out  1  requester index of completed frame, valid with done

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, done_id=0, state=IDLE, last_grant=1 (req0 wins first contest).
- Frame: {1'b1, addr[6:0], data[7:0]}, transmitted MSB first. Bit 15=1 marks a write.
- Handshake: reqN_ready is combinational, high only in IDLE, for the granted requester, while reqN_valid is high. Transfer occurs on valid&&ready. At most one ready is high per cycle. Requesters hold addr/data stable while valid is high and ready is low.
- Arbitration (IDLE only): if exactly one requester is valid, that requester is granted. If both are valid, the requester != last_grant is granted. last_grant updates on accept.
- FSM states: IDLE -> LOW -> HIGH -> (LOW ... ) -> HOLD -> GAP -> IDLE.
- Accept edge: shift register loads the frame, and ncs<=0, copi<=bit15, busy<=1 on that same edge.
- LOW: sclk=0 for CLK_DIV cycles, with copi holding the current bit. Then sclk<=1 and the FSM goes to HIGH.
- HIGH: sclk=1 for CLK_DIV cycles. Then sclk<=0. If bits remain, copi<=next bit and the FSM goes to LOW. After bit 0, the FSM goes to HOLD.
- copi changes only coincident with sclk falling (or at accept). It is stable across every rising edge.
- HOLD: sclk=0, ncs=0 for CLK_DIV cycles. Then ncs<=1, copi<=0, done<=1 for one cycle, done_id=granted index, and the FSM goes to GAP.
- GAP: ncs=1 for CS_GAP cycles. Then busy<=0 and the FSM goes to IDLE. New requests are accepted from the first IDLE cycle.
- Timing: ncs low for 32*CLK_DIV + CLK_DIV cycles (132 at defaults). Exactly 16 sclk rising edges occur per frame. Accept-to-accept spacing is 33*CLK_DIV + CS_GAP + 1 cycles minimum.
- Addresses are not range-checked; any 7-bit address is sent (the peripheral ignores unmapped ones).
- Valid deasserted before ready: no transfer, no error.
- Reset mid-frame: outputs go to reset values immediately. ncs rising aborts the partial frame at the peripheral. No done is issued. Pending requests are re-arbitrated after reset release.
- Bit counter is 4 bits. Terminal detection is at count 0 after the HIGH phase; there is no wrap into a 17th edge.

Test Plan:
- req0 addr=0x00 data=0xA5, CLK_DIV=4 -> copi sampled at 16 sclk rises = 1,0000000,10100101; ncs low 132 cycles; done pulse with done_id=0; busy clears 8 cycles after ncs rises.
- req0 and req1 valid in the same cycle (0x04/0x80, 0x02/0x0F), held -> req0 frame first, then req1; a second simultaneous pair -> req0 first again (last_grant=1).
- req1 valid alone continuously, 3 writes -> ncs high ≥8 cycles between frames; req1_ready never high outside IDLE; accepts spaced 141 cycles.
- Assert rst_n low during bit 7 of a frame -> ncs=1, sclk=0 asynchronously, no done; after release, a still-valid request is re-sent completely.
- Bench checker model of the register-map peripheral (2-flop sync, rising-edge sample) with writes 0x00=0xFF, 0x01=0x0F, 0x04=0x80 -> checker captures all three frames bit-exact; SCLK high/low each ≥4 clk cycles.
- CLK_DIV=255, CS_GAP=2 -> sclk half-period 255 cycles; no counter overflow; frame still has 16 rising edges.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: round-robin arbitration between two register-write requesters and
// serialization of each write into one 16-bit SPI mode-0 frame {1, addr[6:0], data[7:0]}.
// Every SPI output comes straight from a flop so the peripheral's synchronizers see clean edges.
module spi_cfg_sequencer #(
  parameter int unsigned CLK_DIV = 4,  // clk cycles per SCLK half-period, 4..255
  parameter int unsigned CS_GAP  = 8   // clk cycles ncs stays high between frames, 2..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [2:0] {StIdle, StLow, StHigh, StHold, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [14:0] shift_q, shift_d;  // bits still to send after the one on copi
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ncs_q, ncs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;

  logic        grant;
  logic        accept;
  logic        div_last;
  logic        gap_last;
  logic [14:0] frame_low;

  // Grant: a lone requester wins; on contention the one not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && req1_valid && grant;
  assign accept     = req0_ready | req1_ready;
  assign div_last   = (cnt_q == DivLast);
  assign gap_last   = (cnt_q == GapLast);
  // Bit 15 is the constant write marker, so only the low 15 bits need storing.
  assign frame_low  = grant ? {req1_addr, req1_data} : {req0_addr, req0_data};

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      bit_q        <= 4'd0;
      shift_q      <= 15'd0;
      sclk_q       <= 1'b0;
      copi_q       <= 1'b0;
      ncs_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      copi_q       <= copi_d;
      ncs_q        <= ncs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: phase sequencing driven by the shared divider/gap counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLow;
      StLow:   if (div_last) state_d = StHigh;
      StHigh:  if (div_last) state_d = (bit_q == 4'd0) ? StHold : StLow;
      StHold:  if (div_last) state_d = StGap;
      StGap:   if (gap_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: copi only moves at accept or together with sclk falling.
  always_comb begin
    cnt_d        = 8'd0;
    bit_d        = bit_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    copi_d       = copi_q;
    ncs_d        = ncs_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d      = frame_low;
          copi_d       = 1'b1;
          ncs_d        = 1'b0;
          busy_d       = 1'b1;
          bit_d        = 4'd15;
          id_d         = grant;
          last_grant_d = grant;
        end
      end
      StLow: begin
        cnt_d = div_last ? 8'd0 : cnt_q + 8'd1;
        if (div_last) sclk_d = 1'b1;
      end
      StHigh: begin
        cnt_d = div_last ? 8'd0 : cnt_q + 8'd1;
        if (div_last) begin
          sclk_d = 1'b0;
          // Terminal count stops here; the counter never wraps into a 17th bit.
          if (bit_q != 4'd0) begin
            copi_d  = shift_q[14];
            shift_d = {shift_q[13:0], 1'b0};
            bit_d   = bit_q - 4'd1;
          end
        end
      end
      StHold: begin
        cnt_d = div_last ? 8'd0 : cnt_q + 8'd1;
        if (div_last) begin
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      StGap: begin
        cnt_d = gap_last ? 8'd0 : cnt_q + 8'd1;
        if (gap_last) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign sclk    = sclk_q;
  assign copi    = copi_q;
  assign ncs     = ncs_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: default instance plus a CLK_DIV=255 / CS_GAP=2 instance,
// with a register-map peripheral model (2-flop sync, rising-edge sample) on the default one.
module tb_spi_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       sclk, copi, ncs, busy, done, done_id;

  logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [6:0] b_req0_addr, b_req1_addr;
  logic [7:0] b_req0_data, b_req1_data;
  logic       b_sclk, b_copi, b_ncs, b_busy, b_done, b_done_id;

  spi_cfg_sequencer #(.CLK_DIV(4), .CS_GAP(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .sclk       (sclk),
    .copi       (copi),
    .ncs        (ncs),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  spi_cfg_sequencer #(.CLK_DIV(255), .CS_GAP(2)) u_dut_slow (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (b_req0_valid),
    .req0_ready (b_req0_ready),
    .req0_addr  (b_req0_addr),
    .req0_data  (b_req0_data),
    .req1_valid (b_req1_valid),
    .req1_ready (b_req1_ready),
    .req1_addr  (b_req1_addr),
    .req1_data  (b_req1_data),
    .sclk       (b_sclk),
    .copi       (b_copi),
    .ncs        (b_ncs),
    .busy       (b_busy),
    .done       (b_done),
    .done_id    (b_done_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model and timing monitor (default instance) ----------------
  int          cyc = 0;
  logic        sc1 = 0, sc2 = 0, sc3 = 0, cp1 = 0, cp2 = 0, cs1 = 1, cs2 = 1, cs3 = 1;
  logic [15:0] m_shift = 0;
  int          m_bits = 0, last_bits = 0, aborted = 0;
  logic [15:0] frames[$];
  logic        sclk_p = 0, copi_p = 0;
  int          copi_viol = 0;
  int          ncs_lo_len = 0, last_ncs_lo = 0, ncs_hi_len = 0, gap_min = 100000;
  int          lo_run = 0, hi_run = 0;
  int          hi_min = 100000, hi_max = 0, lo_min = 100000, lo_max = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      // Peripheral view: everything through two flops, sample copi on synced sclk rise.
      sc3 = sc2; sc2 = sc1; sc1 = sclk;
      cp2 = cp1; cp1 = copi;
      cs3 = cs2; cs2 = cs1; cs1 = ncs;
      if (!cs2 && cs3) m_bits = 0;
      if (!cs2 && sc2 && !sc3) begin
        m_shift = {m_shift[14:0], cp2};
        m_bits++;
      end
      if (cs2 && !cs3) begin
        last_bits = m_bits;
        if (m_bits == 16) frames.push_back(m_shift);
        else aborted++;
      end
      // Raw pin timing.
      if (sclk && !sclk_p && (copi !== copi_p)) copi_viol++;
      sclk_p = sclk;
      copi_p = copi;
      if (ncs) begin
        if (ncs_lo_len != 0) last_ncs_lo = ncs_lo_len;
        ncs_lo_len = 0;
        ncs_hi_len++;
        lo_run = 0;
        hi_run = 0;
      end else begin
        if (ncs_hi_len != 0 && ncs_hi_len < gap_min) gap_min = ncs_hi_len;
        ncs_hi_len = 0;
        ncs_lo_len++;
        if (sclk) begin
          hi_run++;
          if (lo_run != 0) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          lo_run = 0;
        end else begin
          lo_run++;
          if (hi_run != 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
          end
          hi_run = 0;
        end
      end
    end
  end

  // ---------------- monitor for the slow instance ----------------
  int          b_lo_len = 0, b_last_lo = 0, b_rises = 0, b_hr = 0, b_lr = 0;
  int          b_hi_min = 100000, b_hi_max = 0, b_lo_min = 100000;
  logic        b_sclk_p = 0;
  logic [15:0] b_frame = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (b_ncs) begin
        if (b_lo_len != 0) b_last_lo = b_lo_len;
        b_lo_len = 0;
        b_hr = 0;
        b_lr = 0;
      end else begin
        if (b_lo_len == 0) b_rises = 0;
        b_lo_len++;
        if (b_sclk && !b_sclk_p) begin
          b_rises++;
          b_frame = {b_frame[14:0], b_copi};
        end
        if (b_sclk) begin
          b_hr++;
          if (b_lr != 0 && b_lr < b_lo_min) b_lo_min = b_lr;
          b_lr = 0;
        end else begin
          b_lr++;
          if (b_hr != 0) begin
            if (b_hr < b_hi_min) b_hi_min = b_hr;
            if (b_hr > b_hi_max) b_hi_max = b_hr;
          end
          b_hr = 0;
        end
      end
      b_sclk_p = b_sclk;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] pop_frame();
    if (frames.size() == 0) return 32'hDEAD_BEEF;
    return {16'h0, frames.pop_front()};
  endfunction

  task automatic wait_done(input int lim, input string tag);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(posedge clk); #1;
      if (done) found = 1;
    end
    check(tag, found, 1);
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while (busy && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Holds both requests until each is taken; returns grant order and accept spacing.
  task automatic run_pair(output int first, output int second, output int spacing,
                          output int viol);
    bit   got0 = 0, got1 = 0;
    logic r0, r1;
    int   t0 = 0;
    first = -1; second = -1; spacing = 0; viol = 0;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 1000 && !(got0 && got1); i++) begin
      @(negedge clk);
      r0 = req0_ready;
      r1 = req1_ready;
      if ((r0 && r1) || ((r0 || r1) && busy)) viol++;
      @(posedge clk); #1;
      if (r0 || r1) begin
        if (first < 0) begin
          first = r1 ? 1 : 0;
          t0 = cyc;
        end else begin
          second = r1 ? 1 : 0;
          spacing = cyc - t0;
        end
      end
      if (r0) begin req0_valid = 0; got0 = 1; end
      if (r1) begin req1_valid = 0; got1 = 1; end
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  int   first, second, spacing, viol, n, ab0;
  int   acc[3];
  bit   found;
  logic [6:0] t3_addr[3];
  logic [7:0] t3_data[3];

  initial begin
    rst_n = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    b_req0_valid = 0; b_req0_addr = 0; b_req0_data = 0;
    b_req1_valid = 0; b_req1_addr = 0; b_req1_data = 0;
    t3_addr[0] = 7'h00; t3_data[0] = 8'hFF;
    t3_addr[1] = 7'h01; t3_data[1] = 8'h0F;
    t3_addr[2] = 7'h04; t3_data[2] = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // T1: single write 0x00 = 0xA5 from requester 0.
    req0_addr = 7'h00; req0_data = 8'hA5; req0_valid = 1;
    @(negedge clk);
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    check("t1_accept_ncs", ncs, 0);
    check("t1_accept_busy", busy, 1);
    check("t1_accept_copi", copi, 1);
    check("t1_accept_sclk", sclk, 0);
    wait_done(300, "t1_done_seen");
    check("t1_done_id", done_id, 0);
    check("t1_done_ncs", ncs, 1);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);
    n = 1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_busy_tail", n, 8);
    check("t1_frame", pop_frame(), 32'h80A5);
    check("t1_ncs_low", last_ncs_lo, 132);
    check("t1_rises", last_bits, 16);

    // T2: simultaneous pairs from a fresh reset (last grant = requester 1).
    do_reset();
    req0_addr = 7'h04; req0_data = 8'h80;
    req1_addr = 7'h02; req1_data = 8'h0F;
    run_pair(first, second, spacing, viol);
    check("t2a_first", first, 0);
    check("t2a_second", second, 1);
    check("t2a_spacing", spacing, 141);
    check("t2a_onehot", viol, 0);
    wait_idle(500, "t2a_idle");
    check("t2a_frame0", pop_frame(), 32'h8480);
    check("t2a_frame1", pop_frame(), 32'h820F);
    req0_addr = 7'h10; req0_data = 8'h3C;
    req1_addr = 7'h7F; req1_data = 8'hC3;
    run_pair(first, second, spacing, viol);
    check("t2b_first", first, 0);
    check("t2b_second", second, 1);
    check("t2b_onehot", viol, 0);
    wait_idle(500, "t2b_idle");
    check("t2b_frame0", pop_frame(), 32'h903C);
    check("t2b_frame1", pop_frame(), 32'hFFC3);

    // T3: requester 1 streams three writes with valid held high.
    gap_min = 100000; hi_min = 100000; hi_max = 0; lo_min = 100000; lo_max = 0;
    viol = 0;
    req1_valid = 1;
    for (int k = 0; k < 3; k++) begin
      req1_addr = t3_addr[k];
      req1_data = t3_data[k];
      found = 0;
      acc[k] = 0;
      for (int i = 0; i < 400 && !found; i++) begin
        @(negedge clk);
        if ((req1_ready && busy) || req0_ready) viol++;
        found = req1_ready;
        @(posedge clk); #1;
      end
      acc[k] = cyc;
      check("t3_accept_seen", found, 1);
    end
    req1_valid = 0;
    wait_done(300, "t3_done_seen");
    check("t3_done_id", done_id, 1);
    wait_idle(100, "t3_idle");
    check("t3_ready_outside_idle", viol, 0);
    check("t3_spacing01", acc[1] - acc[0], 141);
    check("t3_spacing12", acc[2] - acc[1], 141);
    check("t3_ncs_gap", gap_min, 9);
    check("t3_frame0", pop_frame(), 32'h80FF);
    check("t3_frame1", pop_frame(), 32'h810F);
    check("t3_frame2", pop_frame(), 32'h8480);
    check("t3_sclk_hi_min", hi_min, 4);
    check("t3_sclk_hi_max", hi_max, 4);
    check("t3_sclk_lo_min", lo_min, 4);
    check("t3_sclk_lo_max", lo_max, 4);

    // T4: reset while bit 7 is on the wire; request stays valid and is re-sent.
    ab0 = aborted;
    req0_addr = 7'h05; req0_data = 8'h5A; req0_valid = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = req0_ready;
      @(posedge clk); #1;
    end
    check("t4_accept_seen", found, 1);
    repeat (66) @(posedge clk);
    #2;
    check("t4_mid_ncs", ncs, 0);
    rst_n = 0;
    #1;
    check("t4_rst_ncs", ncs, 1);
    check("t4_rst_sclk", sclk, 0);
    check("t4_rst_copi", copi, 0);
    check("t4_rst_busy", busy, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("t4_no_done", n, 0);
    rst_n = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = req0_ready;
      @(posedge clk); #1;
    end
    check("t4_reaccept_seen", found, 1);
    req0_valid = 0;
    wait_done(300, "t4_done_seen");
    check("t4_done_id", done_id, 0);
    wait_idle(100, "t4_idle");
    check("t4_aborted", aborted - ab0, 1);
    check("t4_frame", pop_frame(), 32'h855A);
    check("t4_no_extra", frames.size(), 0);
    check("copi_stable_at_rise", copi_viol, 0);

    // T5: slow instance, CLK_DIV=255, CS_GAP=2, write 0x2A = 0x33.
    b_req1_addr = 7'h2A; b_req1_data = 8'h33; b_req1_valid = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = b_req1_ready;
      @(posedge clk); #1;
    end
    check("t5_accept_seen", found, 1);
    b_req1_valid = 0;
    found = 0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(posedge clk); #1;
      if (b_done) found = 1;
    end
    check("t5_done_seen", found, 1);
    check("t5_done_id", b_done_id, 1);
    n = 0;
    while (b_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_busy_tail", n, 2);
    check("t5_rises", b_rises, 16);
    check("t5_hi_min", b_hi_min, 255);
    check("t5_hi_max", b_hi_max, 255);
    check("t5_lo_min", b_lo_min, 255);
    check("t5_ncs_low", b_last_lo, 8415);
    check("t5_frame", b_frame, 32'hAA33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
